// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 16x oversampling tick generator and a valid/ack byte handshake.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int DIV_2400  = 1302,
    parameter int DIV_4800  = 651,
    parameter int DIV_9600  = 326,
    parameter int DIV_19200 = 163
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           baud_rate,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic rx_m, rx_s, rx_d;
    logic [1:0] div_sel;
    logic [10:0] cnt, div_m1;
    logic tick, start_edge, load, ferr;
    logic [3:0] sample_cnt, sample_n;
    logic [2:0] bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;

    assign start_edge = rx_d & ~rx_s;
    assign div_m1 = div_sel == 2'd0 ? 11'(DIV_2400 - 1) :
                    div_sel == 2'd1 ? 11'(DIV_4800 - 1) :
                    div_sel == 2'd2 ? 11'(DIV_9600 - 1) : 11'(DIV_19200 - 1);
    assign tick = cnt == div_m1;
    assign busy = state != IDLE;

    // Tick phase is aligned to the start edge because the counter sits at 0 while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            cnt     <= '0;
            div_sel <= '0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
            if (state == IDLE) begin
                cnt <= '0;
                if (start_edge) div_sel <= baud_rate;
            end else begin
                cnt <= tick ? 11'd0 : cnt + 11'd1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        sample_n = sample_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        load     = 1'b0;
        ferr     = 1'b0;
        case (state)
            IDLE: if (start_edge) begin
                state_n  = START;
                sample_n = '0;
                bit_n    = '0;
            end
            START: if (tick) begin
                sample_n = sample_cnt + 4'd1;
                if (sample_cnt == 4'd7) begin
                    state_n  = rx_s ? IDLE : DATA;
                    sample_n = '0;
                end
            end
            DATA: if (tick) begin
                sample_n = sample_cnt + 4'd1;
                if (sample_cnt == 4'd15) begin
                    shift_n[bit_cnt] = rx_s;
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: if (tick) begin
                sample_n = sample_cnt + 4'd1;
                if (sample_cnt == 4'd15) begin
                    state_n = IDLE;
                    load    = rx_s;
                    ferr    = ~rx_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A new byte always wins over a same-clock ack; only an unacked byte is overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            state         <= state_n;
            sample_cnt    <= sample_n;
            bit_cnt       <= bit_n;
            shift         <= shift_n;
            framing_error <= ferr;
            overrun_error <= load & rx_valid & ~rx_ack;
            if (load) begin
                rx_data  <= shift_n;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector bench for uart_rx, run with scaled-down baud divisors to keep frames short.
module tb_uart_rx;
    localparam int D0 = 48, D1 = 24, D2 = 12, D3 = 6;
    logic clock = 1'b0, reset = 1'b0, rx = 1'b1, rx_ack = 1'b0;
    logic [1:0] baud_rate = 2'd3;
    logic [7:0] rx_data;
    logic rx_valid, framing_error, overrun_error, busy;
    int checks = 0, errors = 0;
    int cyc = 0, t_start = 0, t_valid = 0;
    int ferr_cnt = 0, ovr_cnt = 0, ferr_run = 0, ferr_max = 0;
    logic pv = 1'b0;

    uart_rx #(.DATA_BITS(8), .DIV_2400(D0), .DIV_4800(D1), .DIV_9600(D2), .DIV_19200(D3)) dut (
        .clock(clock), .reset(reset), .baud_rate(baud_rate), .rx(rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .framing_error(framing_error),
        .overrun_error(overrun_error), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (framing_error) begin
            ferr_cnt++;
            ferr_run++;
            if (ferr_run > ferr_max) ferr_max = ferr_run;
        end else begin
            ferr_run = 0;
        end
        if (overrun_error) ovr_cnt++;
        if (rx_valid && !pv) t_valid = cyc;
        pv = rx_valid;
    end

    typedef struct {
        logic [7:0] d;
        logic [1:0] r;
        logic       stop;
        logic       ack;
        logic       ev;
        logic [7:0] ed;
        int         ef;
        int         eo;
    } vec_t;
    vec_t tab[8];

    function automatic int div_of(input logic [1:0] r);
        return r == 2'd0 ? D0 : r == 2'd1 ? D1 : r == 2'd2 ? D2 : D3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] r, input logic stop, input logic [1:0] r_after);
        int bt;
        bt = 16 * div_of(r);
        baud_rate = r;
        @(posedge clock); #1;
        rx = 1'b0;
        t_start = cyc;
        repeat (bt) @(posedge clock);
        #1 baud_rate = r_after;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bt) @(posedge clock);
            #1;
        end
        rx = stop;
        repeat (bt) @(posedge clock);
        #1 rx = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic ack_once();
        @(posedge clock); #1 rx_ack = 1'b1;
        @(posedge clock); #1 rx_ack = 1'b0;
    endtask

    initial begin
        int f0, o0, n;
        tab[0] = '{8'hA5, 2'd3, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
        tab[1] = '{8'h3C, 2'd1, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 0};
        tab[2] = '{8'h00, 2'd0, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0};
        tab[3] = '{8'hFF, 2'd2, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0};
        tab[4] = '{8'h11, 2'd3, 1'b1, 1'b1, 1'b1, 8'h11, 0, 1};
        tab[5] = '{8'h11, 2'd3, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0};
        tab[6] = '{8'h22, 2'd3, 1'b1, 1'b0, 1'b1, 8'h22, 0, 1};
        tab[7] = '{8'h81, 2'd2, 1'b1, 1'b0, 1'b1, 8'h81, 0, 1};

        #2 reset = 1'b1;
        #1;
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_errs", {framing_error, overrun_error}, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);

        for (int i = 0; i < 8; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(tab[i].d, tab[i].r, tab[i].stop, tab[i].r);
            chk($sformatf("v%0d_valid", i), rx_valid, tab[i].ev);
            chk($sformatf("v%0d_data", i), rx_data, tab[i].ed);
            chk($sformatf("v%0d_ferr", i), ferr_cnt - f0, tab[i].ef);
            chk($sformatf("v%0d_ovr", i), ovr_cnt - o0, tab[i].eo);
            chk($sformatf("v%0d_busy", i), busy, 0);
            if (i == 0) chk("latency_19200", t_valid - t_start, 3 + 152 * D3);
            if (tab[i].ef != 0) chk("ferr_width", ferr_max, 1);
            if (tab[i].ack) ack_once();
        end

        // reset asserted in the middle of the data bits of a frame
        baud_rate = 2'd3;
        @(posedge clock); #1 rx = 1'b0;
        repeat (16 * D3 * 3) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", rx_valid, 0);
        chk("midreset_data", rx_data, 0);
        @(posedge clock); #1 reset = 1'b0;
        rx = 1'b1;
        repeat (20) @(posedge clock);
        send_frame(8'hFF, 2'd3, 1'b1, 2'd3);
        chk("after_reset_valid", rx_valid, 1);
        chk("after_reset_data", rx_data, 8'hFF);
        ack_once();
        chk("ack_clears", rx_valid, 0);

        // short low glitch at 9600 must be rejected as a false start
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        baud_rate = 2'd2;
        @(posedge clock); #1 rx = 1'b0;
        repeat (37) @(posedge clock);
        #1 rx = 1'b1;
        chk("glitch_busy", busy, 1);
        n = 0;
        while (busy && n < 80) begin
            @(posedge clock); #1;
            n++;
        end
        chk("glitch_idle", busy, 0);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // baud change mid-frame applies only to the next frame
        send_frame(8'h5A, 2'd3, 1'b1, 2'd0);
        chk("baudchg_valid", rx_valid, 1);
        chk("baudchg_data", rx_data, 8'h5A);
        ack_once();
        send_frame(8'hC3, 2'd0, 1'b1, 2'd0);
        chk("rate2400_valid", rx_valid, 1);
        chk("rate2400_data", rx_data, 8'hC3);
        chk("latency_2400", t_valid - t_start, 3 + 152 * D0);
        ack_once();
        ack_once();
        chk("ack_idle_ignored", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver with an integrated 16x oversampling tick generator.
- Frame format is 8N1: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1). The idle line is high.
- Pairs with the transmit side of the serial link and uses the same 2-bit baud_rate encoding, so both ends select rates identically.
- Delivers each received byte to the core through a valid/ack handshake and reports framing and overrun errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- DIV_2400, 1302, clocks per 16x tick at 2400 baud (50 MHz clock).
- DIV_4800, 651, clocks per 16x tick at 4800 baud.
- DIV_9600, 326, clocks per 16x tick at 9600 baud.
- DIV_19200, 163, clocks per 16x tick at 19200 baud.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- baud_rate  in  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200.
- rx  in  1  serial input, asynchronous to clock, idle high.
- rx_data  out  DATA_BITS  last received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer accepts rx_data; only meaningful while rx_valid=1.
- framing_error  out  1  one-clock pulse: stop bit sampled as 0.
- overrun_error  out  1  one-clock pulse: a new byte arrived while rx_valid=1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous and active-high:
  - rx_data=0, rx_valid=0, framing_error=0, overrun_error=0, busy=0.
  - state=IDLE; synchronizer flops preset to 1; tick counter=0.
- Synchronizer:
  - rx passes through 2 flops to give rx_s.
  - Edge detection uses a third flop, rx_d.
  - Start edge: rx_d=1 and rx_s=0. Latency from an rx pin change to rx_s is 2 clocks.
- Tick generator:
  - Baud_rate is latched into div_sel on the start edge. A baud_rate change mid-frame has no effect until the next frame.
  - Counter counts 0..DIV-1. tick is high for one clock when the counter equals DIV-1, and the counter wraps to 0 on that clock.
  - Counter is held at 0 in IDLE and is cleared on the start edge, so tick phase is aligned to the start edge.
- State machine:
  - IDLE: on the start edge go to START and clear sample_cnt (4 bits) and bit_cnt.
  - START: count ticks. On the 8th tick (mid start bit) sample rx_s.
    - rx_s=1: false start, return to IDLE with no error.
    - rx_s=0: go to DATA with sample_cnt=0.
  - DATA: on every 16th tick, sample rx_s into shift register bit [bit_cnt] (LSB first) and increment bit_cnt. After DATA_BITS samples go to STOP.
  - STOP: on the 16th tick sample rx_s, then return to IDLE on the next clock.
    - rx_s=1: load rx_data from the shift register and set rx_valid=1. If rx_valid was already 1 and no rx_ack arrives in that same clock, also pulse overrun_error; the old byte is lost.
    - rx_s=0: pulse framing_error. rx_data and rx_valid are unchanged.
- Handshake:
  - rx_valid clears on the clock after rx_ack=1 while rx_valid=1.
  - If rx_ack and a new-byte load happen in the same clock, the load wins: rx_valid stays 1 with the new data and there is no overrun.
  - rx_ack while rx_valid=0 is ignored.
- Break condition (line held low): the frame ends with framing_error. The FSM then re-arms only after rx_s has returned to 1, because a start edge requires rx_d=1.
- Widths: tick counter is 11 bits; sample_cnt wraps modulo 16; bit_cnt is 3 bits.
- Latency: rx_valid rises 1 clock after the tick on which the stop bit is sampled.

Test Plan:
- Receive 0xA5 at 19200 (bit = 2608 clocks): rx_valid rises about 9.5 bit times plus 3 clocks after the start edge, rx_data=0xA5, no error pulses.
- Glitch on rx: a 1000-clock low pulse at 9600 baud (half bit = 2608 clocks) returns to IDLE with no rx_valid, no error, and busy low within 2620 clocks.
- Stop bit forced to 0 on byte 0x3C at 4800: framing_error pulses for exactly 1 clock, and rx_valid and rx_data keep their prior values.
- Two back-to-back frames 0x11 then 0x22 with no rx_ack: overrun_error pulses once, rx_data=0x22, rx_valid=1. Repeating with rx_ack after the first byte gives no overrun.
- Change baud_rate from 11 to 00 during frame 0x5A: the byte is still received correctly at 19200, and the next frame is received at 2400.
- Assert reset mid-DATA: all outputs return to 0 immediately, and a following clean frame 0xFF is received correctly.
